// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitAccept,
    StWaitDone,
    StRelease
  } arb_state_t;

  localparam int unsigned DefAcceptTimeout = 4096;
  localparam int unsigned DefMaxRetry      = 2;
  localparam int unsigned MaxReq           = 8;
  localparam int unsigned MaxIdxW          = 3;

  function automatic logic [MaxReq-1:0] onehot(input logic [MaxIdxW-1:0] idx);
    return MaxReq'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NReq = 4,
  localparam int unsigned IdxW = $clog2(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NReq; k++) begin
      sum = {1'b0, ptr_i} + (IdxW+1)'(k);
      // Explicit wrap so non-power-of-two NReq never indexes past the last requester.
      if (sum >= (IdxW+1)'(NReq)) begin
        sum = sum - (IdxW+1)'(NReq);
      end
      cand = sum[IdxW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between NReq requesters, granting whole messages
// round-robin and handshaking each byte via xmit_go_o / synchronised tx_empty_i.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NReq          = 4,
  parameter int unsigned AcceptTimeout = DefAcceptTimeout,
  parameter int unsigned MaxRetry      = DefMaxRetry
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NReq-1:0]   req_i,
  input  logic [8*NReq-1:0] data_i,
  input  logic [NReq-1:0]   last_i,
  output logic [NReq-1:0]   ack_o,
  input  logic              tx_empty_i,
  output logic              xmit_go_o,
  output logic [7:0]        tx_data_o,
  output logic [NReq-1:0]   grant_o,
  output logic              busy_o,
  output logic              fault_o
);

  localparam int unsigned IdxW   = $clog2(NReq);
  localparam int unsigned CntW   = $clog2(AcceptTimeout);
  localparam int unsigned RetryW = $clog2(MaxRetry + 2);

  arb_state_t        state_q;
  logic [1:0]        sync_q;
  logic              txe;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic [RetryW-1:0] retry_q;
  logic              last_q;
  logic [7:0]        tx_data_q;
  logic              xmit_q;
  logic [NReq-1:0]   ack_q;
  logic [NReq-1:0]   grant_q;
  logic              fault_q;

  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;
  logic [7:0]        data_arr [NReq];

  assign txe = sync_q[1];

  always_comb begin
    for (int i = 0; i < NReq; i++) begin
      data_arr[i] = data_i[8*i +: 8];
    end
  end

  rr_pick #(
    .NReq (NReq)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      last_q    <= 1'b0;
      tx_data_q <= '0;
      xmit_q    <= 1'b0;
      ack_q     <= '0;
      grant_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tx_empty_i};
      ack_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= NReq'(onehot(MaxIdxW'(pick_idx)));
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (!req_i[owner_q]) begin
            state_q <= StRelease;
          end else if (txe) begin
            // A retry re-sends the byte already latched.
            if (retry_q == '0) begin
              tx_data_q <= data_arr[owner_q];
              last_q    <= last_i[owner_q];
            end
            xmit_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StWaitAccept;
          end
        end
        StWaitAccept: begin
          if (!txe) begin
            xmit_q  <= 1'b0;
            ack_q   <= grant_q;
            state_q <= StWaitDone;
          end else if (cnt_q == CntW'(AcceptTimeout - 1)) begin
            xmit_q <= 1'b0;
            if (retry_q == RetryW'(MaxRetry)) begin
              fault_q <= 1'b1;
              state_q <= StRelease;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= StLoad;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (txe) begin
            if (last_q || !req_i[owner_q]) begin
              state_q <= StRelease;
            end else begin
              retry_q <= '0;
              state_q <= StLoad;
            end
          end
        end
        StRelease: begin
          grant_q <= '0;
          ptr_q   <= (owner_q == IdxW'(NReq - 1)) ? '0 : owner_q + 1'b1;
          retry_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign xmit_go_o = xmit_q;
  assign tx_data_o = tx_data_q;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != StIdle);
  assign fault_o   = fault_q;

endmodule
